// File: rtl/builtins_pkg.sv
// Shared constants and helpers for the generated streaming building blocks.
package builtins_pkg;

  localparam int MODE_BLOCK   = 0;
  localparam int MODE_SLIDING = 1;

  // Width helper that never returns 0, so single-entry structures still get a 1-bit index.
  function automatic int clog2_1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_to_parallel_buffer_output_stage.sv
// s2p_output_stage: one-entry valid/ready register; a load lands one cycle after the request.
// Holds data while o_valid & !i_ready; the caller only loads when the slot is free or firing.
module s2p_output_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/serial_to_parallel_buffer.sv
// Serial-to-parallel collector: block (non-overlapping) or sliding-window vectors of N_OUTS elements.
// Completing element shows on out_data one cycle after accept; only completing elements stall.
module serial_to_parallel_buffer
  import builtins_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int N_OUTS = 4,
  parameter int MODE   = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_OUTS*WIDTH-1:0]   out_data,
  output logic [$clog2(N_OUTS+1)-1:0] fill
);

  localparam int             FW   = $clog2(N_OUTS + 1);
  localparam logic [FW-1:0]  LAST = FW'(N_OUTS - 1);

  logic [WIDTH-1:0]        r_slot [N_OUTS];
  logic [FW-1:0]           r_fill;
  logic                    w_completes;
  logic                    w_accept;
  logic                    w_load;
  logic [N_OUTS*WIDTH-1:0] w_vec;

  assign fill     = r_fill;
  assign in_ready = !flush & (!w_completes | !out_valid | out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_load   = w_accept & w_completes;

  if (N_OUTS < 1 || N_OUTS > 64) begin : g_bad_n
    $error("serial_to_parallel_buffer: N_OUTS must be in 1..64");
  end

  if (MODE == MODE_BLOCK) begin : g_block
    assign w_completes = (r_fill == LAST);

    // Completing element goes straight to the output; it never occupies a slot.
    always_comb begin
      w_vec = '0;
      for (int i = 0; i < N_OUTS - 1; i++) begin
        w_vec[i*WIDTH +: WIDTH] = r_slot[i];
      end
      w_vec[(N_OUTS-1)*WIDTH +: WIDTH] = in_data;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_fill <= '0;
        for (int i = 0; i < N_OUTS; i++) r_slot[i] <= '0;
      end else if (flush) begin
        r_fill <= '0;
      end else if (w_accept) begin
        if (w_completes) begin
          r_fill <= '0;
        end else begin
          r_fill <= r_fill + FW'(1);
          for (int i = 0; i < N_OUTS; i++) begin
            if (r_fill == FW'(i)) r_slot[i] <= in_data;
          end
        end
      end
    end
  end else if (MODE == MODE_SLIDING) begin : g_sliding
    assign w_completes = (r_fill >= LAST);

    // Window after the shift that this accept performs.
    always_comb begin
      w_vec = '0;
      for (int i = 0; i < N_OUTS - 1; i++) begin
        w_vec[i*WIDTH +: WIDTH] = r_slot[i+1];
      end
      w_vec[(N_OUTS-1)*WIDTH +: WIDTH] = in_data;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_fill <= '0;
        for (int i = 0; i < N_OUTS; i++) r_slot[i] <= '0;
      end else if (flush) begin
        r_fill <= '0;
      end else if (w_accept) begin
        for (int i = 0; i < N_OUTS - 1; i++) r_slot[i] <= r_slot[i+1];
        r_slot[N_OUTS-1] <= in_data;
        if (r_fill != LAST) r_fill <= r_fill + FW'(1);
      end
    end
  end else begin : g_bad_mode
    $error("serial_to_parallel_buffer: MODE must be 0 (block) or 1 (sliding)");
  end

  s2p_output_stage #(
    .DW(N_OUTS * WIDTH)
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush),
    .i_load  (w_load),
    .i_data  (w_vec),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data)
  );

endmodule
